player_input_scheduler: RTL and testbench

//  Sits between the raw controller bits and PlayerLogic; owns the player-action cadence.

---
 rtl/player_input_scheduler.sv | 175 +++++++++++++++++
 tb/tb_player_input_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_scheduler.sv
// Per-frame action scheduler between the raw controller buttons and PlayerLogic.
// Optional build macro SCHED_AUTOREPEAT_EN: a held direction keeps re-latching and repeats moves.
module player_input_scheduler #(
    parameter int ATTACK_HOLD_FRAMES = 11,
    parameter int COOLDOWN_FRAMES    = 8,
    parameter int MOVE_PERIOD_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_in,
    input  logic       frame_end,
    output logic [4:0] input_data,
    output logic       busy,
    output logic [1:0] sched_state
);

    localparam int HOLD_W = $clog2(ATTACK_HOLD_FRAMES + 1);
    localparam int CD_W   = $clog2(COOLDOWN_FRAMES + 1);
    localparam int GAP_W  = $clog2(MOVE_PERIOD_FRAMES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ATTACK_HOLD_FRAMES - 1);
    localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN_FRAMES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MOVE_PERIOD_FRAMES - 1);

    localparam logic [4:0] ATTACK_ACTION = 5'b10000;

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_MOVE     = 2'd1,
        ST_ATTACK   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        input_data_q, input_data_d;
    logic              busy_q, busy_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CD_W-1:0]   cd_cnt_q, cd_cnt_d;
    logic [GAP_W-1:0]  move_gap_q, move_gap_d;
    logic [3:0]        dir_latch_q, dir_latch_d;
    logic              atk_latch_q, atk_latch_d;
    logic              frame_end_q;
    logic              atk_btn_q;

    logic       tick;
    logic       accepting;
    logic       atk_new;
    logic [3:0] dir_new;
    logic [3:0] dir_eff;
    logic       atk_eff;
    logic [3:0] dir_pick;

    assign tick      = frame_end & ~frame_end_q;
    assign accepting = (state_q == ST_COLLECT) || (state_q == ST_MOVE);
    assign atk_new   = btn_in[4] & ~atk_btn_q;

`ifdef SCHED_AUTOREPEAT_EN
    assign dir_new = btn_in[3:0];
`else
    logic [3:0] dir_btn_q;

    assign dir_new = btn_in[3:0] & ~dir_btn_q;

    always_ff @(posedge clk) begin
        if (reset) dir_btn_q <= 4'b0000;
        else       dir_btn_q <= btn_in[3:0];
    end
`endif

    // Presses arriving on the tick cycle itself take part in that tick's resolution.
    assign dir_eff  = dir_latch_q | (accepting ? dir_new : 4'b0000);
    assign atk_eff  = atk_latch_q | (accepting & atk_new);
    assign dir_pick = dir_eff & 4'(~dir_eff + 4'd1);

    always_comb begin
        state_d      = state_q;
        input_data_d = input_data_q;
        hold_cnt_d   = hold_cnt_q;
        cd_cnt_d     = cd_cnt_q;
        move_gap_d   = move_gap_q;
        dir_latch_d  = dir_eff;
        atk_latch_d  = atk_eff;

        if (tick) begin
            dir_latch_d = 4'b0000;
            atk_latch_d = 1'b0;
            if (move_gap_q != '0) move_gap_d = move_gap_q - 1'b1;
        end

        case (state_q)
            ST_COLLECT: begin
                if (tick) begin
                    if (atk_eff) begin
                        input_data_d = ATTACK_ACTION;
                        hold_cnt_d   = HOLD_LOAD;
                        state_d      = ST_ATTACK;
                    end else if ((dir_eff != 4'b0000) && (move_gap_q == '0)) begin
                        input_data_d = {1'b0, dir_pick};
                        move_gap_d   = GAP_LOAD;
                        state_d      = ST_MOVE;
                    end else begin
                        input_data_d = 5'b00000;
                    end
                end
            end
            ST_MOVE: begin
                if (tick) begin
                    if (atk_eff) begin
                        input_data_d = ATTACK_ACTION;
                        hold_cnt_d   = HOLD_LOAD;
                        state_d      = ST_ATTACK;
                    end else begin
                        input_data_d = 5'b00000;
                        state_d      = ST_COLLECT;
                    end
                end
            end
            ST_ATTACK: begin
                if (tick) begin
                    if (hold_cnt_q == '0) begin
                        input_data_d = 5'b00000;
                        cd_cnt_d     = CD_LOAD;
                        state_d      = ST_COOLDOWN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
            end
            ST_COOLDOWN: begin
                input_data_d = 5'b00000;
                if (tick) begin
                    if (cd_cnt_q == '0) state_d = ST_COLLECT;
                    else                cd_cnt_d = cd_cnt_q - 1'b1;
                end
            end
            default: begin
                input_data_d = 5'b00000;
                state_d      = ST_COLLECT;
            end
        endcase

        busy_d = (state_d == ST_ATTACK) || (state_d == ST_COOLDOWN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_COLLECT;
            input_data_q <= 5'b00000;
            busy_q       <= 1'b0;
            hold_cnt_q   <= '0;
            cd_cnt_q     <= '0;
            move_gap_q   <= '0;
            dir_latch_q  <= 4'b0000;
            atk_latch_q  <= 1'b0;
            frame_end_q  <= 1'b0;
            atk_btn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            input_data_q <= input_data_d;
            busy_q       <= busy_d;
            hold_cnt_q   <= hold_cnt_d;
            cd_cnt_q     <= cd_cnt_d;
            move_gap_q   <= move_gap_d;
            dir_latch_q  <= dir_latch_d;
            atk_latch_q  <= atk_latch_d;
            frame_end_q  <= frame_end;
            atk_btn_q    <= btn_in[4];
        end
    end

    assign input_data  = input_data_q;
    assign busy        = busy_q;
    assign sched_state = state_q;

endmodule

// File: tb/tb_player_input_scheduler.sv
// Self-checking bench for player_input_scheduler: directed scenarios plus randomized
// frames, compared every cycle against a frame-count reference model.
module tb_player_input_scheduler;

    localparam int H = 11;
    localparam int C = 8;
    localparam int P = 4;

    logic       clk;
    logic       reset;
    logic [4:0] btn_in;
    logic       frame_end;
    logic [4:0] input_data;
    logic       busy;
    logic [1:0] sched_state;

    int checks = 0;
    int errors = 0;

    // Reference model state, expressed in frames rather than FSM states
    int         m_busy_left;
    logic       m_move_shown;
    logic [3:0] m_shown_dir;
    logic [3:0] m_pend_dir;
    logic       m_pend_atk;
    int         m_tick_no;
    int         m_next_move;
    logic       m_prev_fe;
    logic [4:0] m_prev_btn;

    logic [4:0] exp_data;
    logic       exp_busy;
    logic [1:0] exp_state;

    player_input_scheduler #(
        .ATTACK_HOLD_FRAMES(H),
        .COOLDOWN_FRAMES(C),
        .MOVE_PERIOD_FRAMES(P)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_in(btn_in),
        .frame_end(frame_end),
        .input_data(input_data),
        .busy(busy),
        .sched_state(sched_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(input logic [4:0] b, input logic fe, input logic r);
        logic       tk;
        logic [4:0] rise;
        logic [3:0] dnew;
        logic       found;
        if (r) begin
            m_busy_left  = 0;
            m_move_shown = 1'b0;
            m_shown_dir  = 4'b0;
            m_pend_dir   = 4'b0;
            m_pend_atk   = 1'b0;
            m_tick_no    = 0;
            m_next_move  = 0;
            m_prev_fe    = 1'b0;
            m_prev_btn   = 5'b0;
        end else begin
            tk   = fe && !m_prev_fe;
            rise = b & ~m_prev_btn;
`ifdef SCHED_AUTOREPEAT_EN
            dnew = b[3:0];
`else
            dnew = rise[3:0];
`endif
            if (m_busy_left == 0) begin
                m_pend_dir = m_pend_dir | dnew;
                m_pend_atk = m_pend_atk | rise[4];
            end
            if (tk) begin
                m_tick_no++;
                if (m_busy_left > 0) begin
                    m_busy_left--;
                end else if (m_pend_atk) begin
                    m_busy_left  = H + C;
                    m_move_shown = 1'b0;
                end else if (m_move_shown) begin
                    m_move_shown = 1'b0;
                end else if (m_pend_dir != 4'b0 && m_tick_no >= m_next_move) begin
                    found = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (!found && m_pend_dir[i]) begin
                            m_shown_dir    = 4'b0;
                            m_shown_dir[i] = 1'b1;
                            found          = 1'b1;
                        end
                    end
                    m_move_shown = 1'b1;
                    m_next_move  = m_tick_no + P;
                end
                m_pend_dir = 4'b0;
                m_pend_atk = 1'b0;
            end
            m_prev_fe  = fe;
            m_prev_btn = b;
        end
        exp_busy = (m_busy_left > 0);
        if (m_busy_left > C)      exp_data = 5'b10000;
        else if (m_busy_left > 0) exp_data = 5'b00000;
        else if (m_move_shown)    exp_data = {1'b0, m_shown_dir};
        else                      exp_data = 5'b00000;
        if (m_busy_left > C)      exp_state = 2'd2;
        else if (m_busy_left > 0) exp_state = 2'd3;
        else if (m_move_shown)    exp_state = 2'd1;
        else                      exp_state = 2'd0;
    endtask

    // One clock: drive inputs, advance the model, then compare just after the edge
    task automatic applyStimulus(input logic [4:0] b, input logic fe, input logic r);
        btn_in    = b;
        frame_end = fe;
        reset     = r;
        modelStep(b, fe, r);
        @(posedge clk);
        #1;
        checkOutput("input_data", 16'(input_data), 16'(exp_data));
        checkOutput("busy", 16'(busy), 16'(exp_busy));
        checkOutput("sched_state", 16'(sched_state), 16'(exp_state));
    endtask

    task automatic doTick(input logic [4:0] b, input int fe_len);
        for (int i = 0; i < fe_len; i++) applyStimulus(b, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(b, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic [4:0] b);
        applyStimulus(b, 1'b0, 1'b0);
        applyStimulus(5'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int         atk_cnt;
        int         busy_cnt;
        logic [15:0] move_mask;
        logic [15:0] exp_mask;
        logic [4:0]  rb;
        int          fe_len;
        int          gap;

        btn_in    = 5'b0;
        frame_end = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(5'b0, 1'b0, 1'b1);
        checkOutput("reset_data", 16'(input_data), 16'h0);
        checkOutput("reset_state", 16'(sched_state), 16'h0);

        // T1: reset held mid-attack aborts it
        pulse(5'b10000);
        doTick(5'b0, 1);
        doTick(5'b0, 1);
        checkOutput("t1_attacking", 16'(input_data), 16'h10);
        for (int i = 0; i < 3; i++) applyStimulus(5'b0, 1'b0, 1'b1);
        checkOutput("t1_data", 16'(input_data), 16'h0);
        checkOutput("t1_busy", 16'(busy), 16'h0);
        checkOutput("t1_state", 16'(sched_state), 16'h0);

        // T2: single down press gives one frame of move
        applyStimulus(5'b0, 1'b0, 1'b0);
        pulse(5'b00010);
        doTick(5'b0, 1);
        checkOutput("t2_move", 16'(input_data), 16'h02);
        checkOutput("t2_state", 16'(sched_state), 16'h1);
        doTick(5'b0, 1);
        checkOutput("t2_clear", 16'(input_data), 16'h0);

        // T3: attack wins over directions; 11 attack frames, 19 busy frames
        pulse(5'b10101);
        doTick(5'b0, 1);
        atk_cnt  = (input_data == 5'b10000) ? 1 : 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k < 25; k++) begin
            doTick(5'b0, 1);
            if (input_data == 5'b10000) atk_cnt++;
            if (busy) busy_cnt++;
        end
        checkOutput("t3_attack_frames", 16'(atk_cnt), 16'(H));
        checkOutput("t3_busy_frames", 16'(busy_cnt), 16'(H + C));
        checkOutput("t3_final_state", 16'(sched_state), 16'h0);

        // T4: left beats right
        pulse(5'b01100);
        doTick(5'b0, 1);
        checkOutput("t4_left", 16'(input_data), 16'h04);
        for (int k = 0; k < 4; k++) doTick(5'b0, 1);

        // T5: held up button across 12 ticks
        move_mask = 16'h0;
        for (int k = 0; k < 12; k++) begin
            doTick(5'b00001, 1);
            if (input_data == 5'b00001) move_mask[k] = 1'b1;
        end
`ifdef SCHED_AUTOREPEAT_EN
        exp_mask = 16'h0111;
`else
        exp_mask = 16'h0001;
`endif
        checkOutput("t5_move_ticks", move_mask, exp_mask);
        for (int k = 0; k < 4; k++) doTick(5'b0, 1);

        // T6: long frame_end strobe counts once; attack during cooldown ignored
        pulse(5'b10000);
        doTick(5'b0, 4);
        atk_cnt  = (input_data == 5'b10000) ? 1 : 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k < 25; k++) begin
            if (k == 14) begin
                checkOutput("t6_in_cooldown", 16'(sched_state), 16'h3);
                pulse(5'b10000);
            end
            doTick(5'b0, 4);
            if (input_data == 5'b10000) atk_cnt++;
            if (busy) busy_cnt++;
        end
        checkOutput("t6_attack_frames", 16'(atk_cnt), 16'(H));
        checkOutput("t6_busy_frames", 16'(busy_cnt), 16'(H + C));
        checkOutput("t6_final_state", 16'(sched_state), 16'h0);

        // Randomized frames with occasional resets, checked every cycle by the model
        rb = 5'b0;
        for (int f = 0; f < 300; f++) begin
            fe_len = $urandom_range(1, 3);
            gap    = $urandom_range(3, 10);
            for (int c = 0; c < fe_len + gap; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rb = 5'($urandom_range(0, 31));
                    if (rb[4] && $urandom_range(0, 2) != 0) rb[4] = 1'b0;
                end
                applyStimulus(rb, (c < fe_len), ($urandom_range(0, 499) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
